// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_RUN  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_e;

  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM
  function automatic logic op_rs1_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV) || (f == MD_REM);
  endfunction

  // rs2 is signed for MUL/MULH/DIV/REM
  function automatic logic op_rs2_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  md_mode_e              mode,
  input  logic [2*XLEN-1:0]     acc,
  input  logic [XLEN-1:0]       operand,
  output logic [2*XLEN-1:0]     acc_nxt
);

  logic [XLEN:0]       sum;
  logic [XLEN:0]       diff;
  logic [2*XLEN-1:0]   shl;

  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : (XLEN+1)'(0));
    shl     = {acc[2*XLEN-2:0], 1'b0};
    // bit shifted out of the remainder keeps the partial remainder XLEN+1 bits wide
    diff    = {acc[2*XLEN-1], shl[2*XLEN-1:XLEN]} - {1'b0, operand};
    acc_nxt = shl;
    if (mode == MODE_MUL) begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_nxt = {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Fixed-latency RV32M multiply/divide sequencer; holds the pipeline via stall
// and returns a registered result with a one-cycle done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     AW       = 2 * XLEN;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state, state_nxt;
  md_mode_e        mode;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, opnd;
  logic [AW-1:0]   acc, acc_step, prod_s;
  logic [CNTW-1:0] cnt;
  logic            neg_main, neg_rem;
  logic            accept, busy_nxt, done_nxt;
  logic            s1, s2;
  logic [XLEN-1:0] a_abs, b_abs, quo_s, rem_s, fix_val;

  assign accept = start & ~flush;
  assign mode   = op[2] ? MODE_DIV : MODE_MUL;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode    (mode),
    .acc     (acc),
    .operand (opnd),
    .acc_nxt (acc_step)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = MD_PREP;
      MD_PREP: state_nxt = MD_RUN;
      MD_RUN:  if (cnt == CNT_LAST) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush) state_nxt = MD_IDLE;
  end

  // output decode; stall is combinational so the request cycle already freezes EX
  always_comb begin
    stall    = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      MD_IDLE:                  stall = accept;
      MD_PREP, MD_RUN, MD_FIX:  stall = 1'b1;
      default:                  stall = 1'b0;
    endcase
    busy_nxt = (state_nxt == MD_PREP) || (state_nxt == MD_RUN) || (state_nxt == MD_FIX);
    done_nxt = (state_nxt == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // operand magnitudes and sign selection
  always_comb begin
    s1    = op_rs1_signed(op) & a[XLEN-1];
    s2    = op_rs2_signed(op) & b[XLEN-1];
    a_abs = s1 ? -a : a;
    b_abs = s2 ? -b : b;
  end

  // sign fix-up, word select and divide special cases
  always_comb begin
    prod_s = neg_main ? -acc : acc;
    quo_s  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = neg_rem  ? -acc[AW-1:XLEN] : acc[AW-1:XLEN];
    case (op)
      MD_MUL:                      fix_val = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_s[AW-1:XLEN];
      MD_DIV, MD_DIVU:             fix_val = quo_s;
      default:                     fix_val = rem_s;
    endcase
    if (op[2]) begin
      if (b == '0) begin
        fix_val = op[1] ? a : '1;
      end else if (!op[0] && (a == INT_MIN) && (b == '1)) begin
        fix_val = op[1] ? '0 : INT_MIN;
      end
    end
  end

  // datapath: operand latch, accumulator, counter, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= 3'b000;
      a        <= '0;
      b        <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            op <= funct3;
            a  <= rs1;
            b  <= rs2;
          end
        end
        MD_PREP: begin
          acc      <= op[2] ? {XLEN'(0), a_abs} : {XLEN'(0), b_abs};
          opnd     <= op[2] ? b_abs : a_abs;
          neg_main <= s1 ^ s2;
          neg_rem  <= s1;
          cnt      <= '0;
        end
        MD_RUN: begin
          acc <= acc_step;
          cnt <= cnt + CNTW'(1);
        end
        MD_FIX: begin
          if (!flush) result <= fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M cases, control corners and
// random operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        stall, busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'h0;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        ua, ub, pu;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * $signed(ub); return p[63:32]; end
      3'b011: begin pu = ua * ub; return pu[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Monitor: every done must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: result 0x%08h at cycle %0d", result, cyc);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("stall_in_done", {31'h0, stall}, 32'h0);
          chk("busy_in_done", {31'h0, busy}, 32'h0);
          last_res = e.res;
        end
      end
    end
  end

  // Drive one request for a single cycle; optionally record its expected result
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
    exp_t e;
    @(negedge clk); #1;
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    #1;
    chk("stall_on_start", {31'h0, stall}, 32'h1);
    if (push) begin
      e.res = exp;
      e.cyc = cyc + 35;
      sb.push_back(e);
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    issue(f, a, b, 1'b1, exp);
    drain(60);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
  } dir_t;

  dir_t dirs[$];

  initial begin
    exp_t e;
    int   c0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;

    // Directed cases with hand-derived results
    dirs.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    dirs.push_back('{3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    dirs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    dirs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dirs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    dirs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    dirs.push_back('{3'b101, 32'd100, 32'd7, 32'd14});
    dirs.push_back('{3'b111, 32'd100, 32'd7, 32'd2});
    dirs.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF});
    dirs.push_back('{3'b110, 32'd5, 32'd0, 32'd5});
    dirs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    dirs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    dirs.push_back('{3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1});
    dirs.push_back('{3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE});
    foreach (dirs[i]) run_op(dirs[i].f, dirs[i].a, dirs[i].b, dirs[i].exp);

    // Flush in RUN cycle 10: back to IDLE, no done, result kept
    issue(3'b000, 32'd1234, 32'd5678, 1'b0, 32'h0);
    repeat (11) begin @(negedge clk); #1; end
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_stall", {31'h0, stall}, 32'h0);
    chk("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    #1;
    chk("flush_result_held", result, last_res);

    // Reset in RUN cycle 20
    issue(3'b101, 32'd999, 32'd3, 1'b0, 32'h0);
    repeat (21) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("midrst_result", result, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    last_res = 32'h0;
    repeat (40) @(negedge clk);

    // start with flush in IDLE is dropped
    @(negedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
    #1;
    chk("startflush_stall", {31'h0, stall}, 32'h0);
    @(negedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    #1;
    chk("startflush_result", result, 32'h0);

    // start held through two operations; operands change mid-operation
    @(negedge clk); #1;
    c0 = cyc;
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD;
    e.res = 32'hFFFF_FFEB; e.cyc = c0 + 35; sb.push_back(e);
    @(negedge clk); #1;
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    e.res = 32'd14; e.cyc = c0 + 71; sb.push_back(e);
    while (cyc < c0 + 71) begin @(negedge clk); #1; end
    start = 1'b0;
    drain(10);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f, a, b, ref_md(f, a, b));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
